game_round_controller: RTL and testbench
========================================

# game_round_controller

Round sequencer for the keypad/stepper-motor guessing game. Each round it latches a target from the pseudo-random generator, commands the stepper wrapper to move, then opens a timed guess window for the keypad. It judges the guess against the target, keeps a saturating score for the seven-segment display, and ends the game after a fixed number of rounds.

## Interface
- MOVE_CYCLES, default 2_000_000: minimum clk cycles spent in MOVE before a guess is accepted (≥1).
- GUESS_CYCLES, default 300_000_000: guess window length in clk cycles (≥1).
- ROUNDS, default 9: rounds per game (1..15).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  level from start button, already debounced; rising edge is detected internally.
- key_valid  in  1  one-cycle pulse per keypad press.
- key_value  in  4  mapped key code; valid with key_valid.
- rnd  in  4  current PRNG value.
- motor_busy  in  1  stepper is still stepping.
- target  out  4  latched target; drives the motor direction/speed inputs.
- motor_go  out  1  one-cycle move command.
- score  out  4  hits, 0..9 (BCD digit).
- round  out  4  completed rounds, 0..ROUNDS.
- phase  out  3  FSM state code: IDLE=0, LOAD=1, MOVE=2, GUESS=3, JUDGE=4, DONE=5.
- hit, miss  out  1  one-cycle judge result pulses.
- game_over  out  1  high while in DONE.

## Operation
- Reset values: phase=IDLE, target=0, score=0, round=0, motor_go=0, hit=0, miss=0, game_over=0. The internal timer and the start_prev register are also cleared.
- Rising edge of start: start=1 and start_prev=0. start_prev is a register updated every cycle.
- IDLE: on start rising edge, clear score and round, then go to LOAD.
- LOAD: exactly one cycle. Capture target <= rnd. Go to MOVE.
- MOVE: timer starts at 0 on entry and increments each cycle. Exit to GUESS when timer ≥ MOVE_CYCLES-1 and motor_busy=0. If motor_busy is still high after the timer expires, remain in MOVE; the timer saturates.
- GUESS: timer restarts at 0.
  - On key_valid, capture key_value and go to JUDGE with timed_out=0.
  - If timer reaches GUESS_CYCLES-1 with no key, go to JUDGE with timed_out=1.
  - If key_valid and expiry coincide, the key wins.
- JUDGE: exactly one cycle.
  - hit=1 if !timed_out and the captured key equals target; otherwise miss=1.
  - On hit, score increments, saturating at 9.
  - round increments.
  - If the new round equals ROUNDS, go to DONE; otherwise go to LOAD.
- DONE: game_over=1; score and round hold. A start rising edge behaves as in IDLE: clear score and round, go to LOAD.
- Ignored inputs:
  - key_valid outside GUESS has no effect; it is not queued.
  - A start edge outside IDLE/DONE is ignored.
  - start held high across DONE does not restart; a new rising edge is required.
- Timer: 32-bit unsigned.
- Asserting reset in any state returns all outputs to reset values immediately, without waiting for clk. Operation resumes in IDLE after release.

## Timing
- Start edge sampled at edge N → phase=LOAD at N+1, MOVE at N+2.
- target takes its new value in the first MOVE cycle. motor_go is high for exactly that cycle. Both are registered outputs.
- With motor_busy=0 throughout, MOVE lasts MOVE_CYCLES cycles.
- key_valid sampled in GUESS at edge K → JUDGE in cycle K+1 with hit/miss high → score and round updated and phase=LOAD (or DONE) at K+2.
- On timeout, GUESS lasts GUESS_CYCLES cycles, then JUDGE follows.
- Minimum round length with a key in the first GUESS cycle: 1 (LOAD) + MOVE_CYCLES + 1 + 1 (JUDGE) cycles.
- phase, game_over, score and round are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Bench parameters: MOVE_CYCLES=4, GUESS_CYCLES=8, ROUNDS=3.
- Reset, then start pulse with rnd=5 → motor_go single pulse with target=5, phase 1→2, and GUESS entered 4 cycles after MOVE entry.
- In GUESS, key_valid with key_value=5 → hit pulse, score 0→1, round 0→1, next phase=LOAD. With key_value=6 → miss, score unchanged.
- No key in GUESS → miss after exactly 8 GUESS cycles. key_valid on the 8th cycle → judged as a key, not a timeout.
- motor_busy held high for 10 cycles in MOVE → GUESS entered only after motor_busy falls. key_valid during MOVE → ignored, no JUDGE.
- Three rounds all hit → score=3, round=3, game_over=1, phase=DONE. With start held high, no restart; a new rising edge → score=0, round=0, LOAD. Force score to 9 with ROUNDS=15 → a further hit keeps score=9.
- reset asserted mid-GUESS between clock edges → all outputs return to reset values immediately. After release, start still works.

Source files
------------

// File: rtl/game_round_controller.sv
// Round sequencer for the keypad/stepper guessing game.
// Latches a target, commands a move, times the guess window and keeps score.
module game_round_controller #(
    parameter int unsigned MOVE_CYCLES  = 2_000_000,
    parameter int unsigned GUESS_CYCLES = 300_000_000,
    parameter int unsigned ROUNDS       = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    input  logic [3:0] rnd,
    input  logic       motor_busy,
    output logic [3:0] target,
    output logic       motor_go,
    output logic [3:0] score,
    output logic [3:0] round,
    output logic [2:0] phase,
    output logic       hit,
    output logic       miss,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MOVE  = 3'd2,
        GUESS = 3'd3,
        JUDGE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] MOVE_LAST  = 32'(MOVE_CYCLES - 1);
    localparam logic [31:0] GUESS_LAST = 32'(GUESS_CYCLES - 1);
    localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  target_q, target_d;
    logic [3:0]  score_q, score_d;
    logic [3:0]  round_q, round_d;
    logic        start_prev_q, start_prev_d;
    logic        motor_go_q, motor_go_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        game_over_q, game_over_d;
    logic        start_rise;

    assign start_rise = start & ~start_prev_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        target_d     = target_q;
        score_d      = score_q;
        round_d      = round_q;
        start_prev_d = start;
        motor_go_d   = 1'b0;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    score_d = 4'd0;
                    round_d = 4'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                target_d   = rnd;
                motor_go_d = 1'b1;
                timer_d    = 32'd0;
                state_d    = MOVE;
            end
            MOVE: begin
                // timer saturates while the stepper is still busy
                if (timer_q >= MOVE_LAST) begin
                    if (!motor_busy) begin
                        timer_d = 32'd0;
                        state_d = GUESS;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            GUESS: begin
                if (key_valid) begin
                    hit_d   = (key_value == target_q);
                    miss_d  = (key_value != target_q);
                    state_d = JUDGE;
                end else if (timer_q >= GUESS_LAST) begin
                    miss_d  = 1'b1;
                    state_d = JUDGE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            JUDGE: begin
                if (hit_q && score_q < 4'd9) begin
                    score_d = score_q + 4'd1;
                end
                round_d = round_q + 4'd1;
                if (round_q + 4'd1 == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= 32'd0;
            target_q     <= 4'd0;
            score_q      <= 4'd0;
            round_q      <= 4'd0;
            start_prev_q <= 1'b0;
            motor_go_q   <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            target_q     <= target_d;
            score_q      <= score_d;
            round_q      <= round_d;
            start_prev_q <= start_prev_d;
            motor_go_q   <= motor_go_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            game_over_q  <= game_over_d;
        end
    end

    assign target    = target_q;
    assign motor_go  = motor_go_q;
    assign score     = score_q;
    assign round     = round_q;
    assign phase     = state_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Randomized scoreboard bench for game_round_controller.
// Round-level reference model feeds a queue checked on each judge pulse.
module tb_game_round_controller;

    localparam int MC = 4;
    localparam int GC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic [3:0] rnd = 4'd0;
    logic       motor_busy = 1'b0;
    logic       sel = 1'b0;

    logic [3:0] a_tgt, a_score, a_round, b_tgt, b_score, b_round;
    logic [2:0] a_ph, b_ph;
    logic       a_go, a_hit, a_miss, a_over;
    logic       b_go, b_hit, b_miss, b_over;

    logic [3:0] tgt_m, score_m, round_m;
    logic [2:0] ph_m;
    logic       go_m, hit_m, miss_m, over_m;

    game_round_controller #(
        .MOVE_CYCLES(MC), .GUESS_CYCLES(GC), .ROUNDS(3)
    ) u_r3 (
        .clk(clk), .reset(reset), .start(start),
        .key_valid(key_valid), .key_value(key_value),
        .rnd(rnd), .motor_busy(motor_busy),
        .target(a_tgt), .motor_go(a_go), .score(a_score),
        .round(a_round), .phase(a_ph), .hit(a_hit),
        .miss(a_miss), .game_over(a_over)
    );

    game_round_controller #(
        .MOVE_CYCLES(MC), .GUESS_CYCLES(GC), .ROUNDS(15)
    ) u_r15 (
        .clk(clk), .reset(reset), .start(start),
        .key_valid(key_valid), .key_value(key_value),
        .rnd(rnd), .motor_busy(motor_busy),
        .target(b_tgt), .motor_go(b_go), .score(b_score),
        .round(b_round), .phase(b_ph), .hit(b_hit),
        .miss(b_miss), .game_over(b_over)
    );

    assign tgt_m   = sel ? b_tgt   : a_tgt;
    assign score_m = sel ? b_score : a_score;
    assign round_m = sel ? b_round : a_round;
    assign ph_m    = sel ? b_ph    : a_ph;
    assign go_m    = sel ? b_go    : a_go;
    assign hit_m   = sel ? b_hit   : a_hit;
    assign miss_m  = sel ? b_miss  : a_miss;
    assign over_m  = sel ? b_over  : a_over;

    always #5 clk = ~clk;

    typedef struct {
        int tgt;
        int move_len;
        int guess_len;
        int hit;
        int score;
        int round;
        int done;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   rounds_cfg = 3;
    int   m_score = 0;
    int   m_round = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        int   move_cnt;
        int   guess_cnt;
        int   seen_tgt;
        bit   post;
        int   prev_go;
        int   prev_ph;
        move_cnt = 0;
        guess_cnt = 0;
        seen_tgt = 0;
        post = 0;
        prev_go = 0;
        prev_ph = 0;
        forever begin
            @(negedge clk);
            if (post) begin
                post = 0;
                chk("score_after", int'(score_m), e.score);
                chk("round_after", int'(round_m), e.round);
                chk("phase_after", int'(ph_m), e.done ? 5 : 1);
                chk("game_over_after", int'(over_m), e.done);
            end
            if (go_m) begin
                chk("motor_go_width", prev_go, 0);
                chk("load_before_move", prev_ph, 1);
                chk("phase_at_go", int'(ph_m), 2);
                seen_tgt = int'(tgt_m);
                move_cnt = 0;
                guess_cnt = 0;
            end
            if (ph_m == 3'd2) move_cnt++;
            if (ph_m == 3'd3) guess_cnt++;
            if (hit_m || miss_m) begin
                chk("judge_expected", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("target", seen_tgt, e.tgt);
                    chk("move_len", move_cnt, e.move_len);
                    chk("guess_len", guess_cnt, e.guess_len);
                    chk("hit", int'(hit_m), e.hit);
                    chk("miss", int'(miss_m), 1 - e.hit);
                    chk("phase_judge", int'(ph_m), 4);
                    post = 1;
                end
            end
            prev_go = int'(go_m);
            prev_ph = int'(ph_m);
        end
    end

    task automatic check_reset_vals(string tag);
        chk({tag, "_phase"}, int'(ph_m), 0);
        chk({tag, "_target"}, int'(tgt_m), 0);
        chk({tag, "_score"}, int'(score_m), 0);
        chk({tag, "_round"}, int'(round_m), 0);
        chk({tag, "_motor_go"}, int'(go_m), 0);
        chk({tag, "_hit"}, int'(hit_m), 0);
        chk({tag, "_miss"}, int'(miss_m), 0);
        chk({tag, "_game_over"}, int'(over_m), 0);
    endtask

    task automatic start_game(input logic [3:0] first_rnd, input bit hold);
        m_score = 0;
        m_round = 0;
        rnd = first_rnd;
        start = 1'b1;
        @(negedge clk);
        chk("start_phase", int'(ph_m), 1);
        chk("start_score", int'(score_m), 0);
        chk("start_round", int'(round_m), 0);
        if (!hold) start = 1'b0;
    endtask

    task automatic play_round(
        input logic [3:0] r_tgt, input logic [3:0] next_rnd,
        input int busy, input bit has_key, input int k,
        input logic [3:0] kv, input bit noise
    );
        exp_t e;
        bit   ok;
        e.tgt = int'(r_tgt);
        e.move_len = (busy + 1 > MC) ? busy + 1 : MC;
        e.guess_len = has_key ? k : GC;
        e.hit = int'(has_key && kv == r_tgt);
        if (e.hit == 1 && m_score < 9) m_score++;
        m_round++;
        e.score = m_score;
        e.round = m_round;
        e.done = int'(m_round == rounds_cfg);
        sbq.push_back(e);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (go_m) begin
                ok = 1;
                break;
            end
        end
        chk("motor_go_seen", int'(ok), 1);
        if (!ok) return;
        rnd = next_rnd;
        ok = 0;
        for (int c = 1; c <= 60; c++) begin
            motor_busy = (c <= busy);
            key_valid = noise && c == 2;
            key_value = r_tgt;
            if (noise) start = (c == 3);
            @(negedge clk);
            if (ph_m == 3'd3) begin
                ok = 1;
                break;
            end
        end
        motor_busy = 1'b0;
        key_valid = 1'b0;
        if (noise) start = 1'b0;
        chk("guess_reached", int'(ok), 1);
        if (!ok) return;
        ok = 0;
        for (int g = 1; g <= GC + 4; g++) begin
            key_valid = has_key && g == k;
            key_value = kv;
            @(negedge clk);
            if (ph_m != 3'd3) begin
                ok = 1;
                break;
            end
        end
        key_valid = 1'b0;
        chk("guess_left", int'(ok), 1);
    endtask

    task automatic random_game(input int n, input bit all_hit);
        logic [3:0] cur, nxt, kv;
        bit         hk;
        start = 1'b0;
        @(negedge clk);
        cur = 4'($urandom_range(0, 15));
        start_game(cur, 0);
        for (int r = 0; r < n; r++) begin
            nxt = 4'($urandom_range(0, 15));
            hk = all_hit || ($urandom_range(0, 3) != 0);
            kv = ($urandom_range(0, 1) == 1 || all_hit) ?
                 cur : 4'($urandom_range(0, 15));
            play_round(cur, nxt, int'($urandom_range(0, 7)), hk,
                       int'($urandom_range(1, GC)), kv, 0);
            cur = nxt;
        end
        repeat (2) @(negedge clk);
        chk("rand_game_done", int'(ph_m), 5);
        chk("rand_game_round", int'(round_m), n);
    endtask

    initial begin : driver
        bit ok;
        #2;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_hold", int'(ph_m), 0);

        start_game(4'd5, 1);
        play_round(4'd5, 4'd9, 0, 1, 1, 4'd5, 0);
        play_round(4'd9, 4'd2, 0, 1, 3, 4'd9, 0);
        play_round(4'd2, 4'd7, 2, 1, 5, 4'd2, 0);
        repeat (4) @(negedge clk);
        chk("held_start_phase", int'(ph_m), 5);
        chk("held_start_over", int'(over_m), 1);
        chk("held_start_score", int'(score_m), 3);
        chk("held_start_round", int'(round_m), 3);
        start = 1'b0;
        @(negedge clk);

        start_game(4'd7, 0);
        play_round(4'd7, 4'd3, 0, 1, 2, 4'd6, 0);
        play_round(4'd3, 4'd11, 0, 0, 0, 4'd0, 0);
        play_round(4'd11, 4'd4, 10, 1, GC, 4'd11, 1);
        repeat (2) @(negedge clk);
        chk("game2_score", int'(score_m), 1);

        for (int g = 0; g < 4; g++) random_game(3, 0);

        start = 1'b0;
        @(negedge clk);
        start_game(4'd4, 0);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ph_m == 3'd3) begin
                ok = 1;
                break;
            end
        end
        chk("mid_guess_reached", int'(ok), 1);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        sel = 1'b1;
        rounds_cfg = 15;
        reset = 1'b1;

        random_game(15, 1);
        chk("sat_score", int'(score_m), 9);
        chk("sat_over", int'(over_m), 1);
        chk("queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
